bike_motion_tracker: RTL
========================

Name: bike_motion_tracker

Overview:
- Consumer of the 32-bit orientation word produced by the lightbike button/orientation logic. Advances one bike's pixel location on the 640x480 playfield once per movement step.
- Checks each candidate location against screen edges and the trail memory. Writes the vacated pixel into the trail memory.
- Raises `crash`, which feeds back to the orientation logic and forces the orientation word to 0.

Parameters:
- SCREEN_W, 640, playfield width in pixels; also the vertical step magnitude.
- SCREEN_H, 480, playfield height in pixels.
- START_X, 320, x coordinate loaded on reset/start.
- START_Y, 240, y coordinate loaded on reset/start.
- STEP_DIV, 4, number of `tick` pulses per one-pixel move (>=1).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; (re)starts a round from START_X/START_Y
- tick  in  1  one-cycle frame/step pulse
- orient  in  32  direction word: 1 = +x, 0xFFFFFFFF = -x, 640 = +y, 0xFFFFFD80 (-640) = -y, 0 = crashed/stop
- trail_rd_addr  out  32  linear address y*SCREEN_W+x of the candidate pixel
- trail_rd_data  in  1  occupancy of trail_rd_addr; valid exactly 1 cycle after the address is presented
- trail_wr_en  out  1  one-cycle write strobe
- trail_wr_addr  out  32  pixel to mark occupied
- location  out  32  current linear location y*SCREEN_W+x
- pos_x  out  10  current x
- pos_y  out  9  current y
- crash  out  1  sticky crash flag
- running  out  1  high while in RUN, FETCH or CHECK

Behaviour:
- Reset values:
  - state = IDLE; pos_x = START_X; pos_y = START_Y; location = START_Y*640+START_X (153920 with defaults).
  - crash = 0; trail_wr_en = 0; step counter = 0; last_dir = +x.
- States: IDLE, RUN, FETCH, CHECK, CRASHED.
- IDLE: `start` -> RUN. Position and counter reload to start values; crash clears.
- RUN: on each `tick`, the step counter increments. When it reaches STEP_DIV-1 the counter clears, the direction is decoded, and the state goes to FETCH. Non-tick cycles hold.
- Direction decode uses `orient` sampled on that cycle:
  - 0 -> CRASHED immediately.
  - Exact opposite of last_dir -> use last_dir (reversal rejected).
  - Any value other than the four legal codes and 0 -> use last_dir.
- Edge check happens in the decode cycle:
  - x==0 moving -x, x==SCREEN_W-1 moving +x, y==0 moving -y, or y==SCREEN_H-1 moving +y -> CRASHED.
  - No wrap-around.
- FETCH: trail_rd_addr = candidate address, held stable through CHECK.
- CHECK (1 cycle later): if trail_rd_data==1, go to CRASHED with position unchanged.
- Otherwise, in the same cycle:
  - trail_wr_en = 1 and trail_wr_addr = old location.
  - Position updates; last_dir = applied direction.
  - Next state is RUN.
- Move latency: 2 cycles after the qualifying tick. The location update is visible on the 3rd clock edge after the tick.
- Ticks arriving during FETCH/CHECK are dropped; they do not increment the counter.
- CRASHED: crash = 1 and held. Position frozen; no trail writes. `start` -> RUN with reload and crash cleared. `tick` is ignored.
- `start` in RUN/FETCH/CHECK aborts the step in progress: no write, reload, go to RUN.
- `reset` has priority over `start`. `start` has priority over `tick`.
- location is always pos_y*SCREEN_W+pos_x, registered coherently with pos_x/pos_y.
- Arithmetic is unsigned 10/9-bit for coordinates. Address math is 32-bit with no truncation.

Decomposition:
- Shared package `lightbike_pkg`:
  - Direction constants: DIR_RIGHT = 1, DIR_LEFT = 32'hFFFFFFFF, DIR_DOWN = 640, DIR_UP = 32'hFFFFFD80, DIR_STOP = 0.
  - SCREEN_W and SCREEN_H.
  - State encoding.
- One sub-module, `orient_decode`: combinational. Maps orient, last_dir, pos_x and pos_y to {dx, dy, applied_dir, edge_hit, stop}.

Test Plan:
- Reset, then start, orient=1, STEP_DIV=4, 8 ticks with trail all 0 -> pos_x=322, pos_y=240, location=153922. Exactly 2 trail writes, at 153920 and 153921.
- Moving +x, then orient=0xFFFFFFFF -> reversal ignored, x keeps increasing. Then orient=640 -> y increments by 1 per step, location increments by 640.
- Start at x=639 (START_X=639), orient=1, STEP_DIV ticks -> crash=1, location unchanged, no write. Further ticks make no change.
- trail_rd_data=1 returned for candidate 153921 -> crash=1 during the CHECK cycle, location stays 153920, trail_wr_en never asserted.
- orient=0 on a qualifying tick -> CRASHED. Then a start pulse -> crash=0, location=153920, movement resumes.
- start asserted in the FETCH cycle -> no trail write, location reloads to 153920, state RUN. Reset asserted simultaneously with start -> IDLE.

Source files
------------

// File: rtl/lightbike_pkg.sv
// Shared lightbike definitions: playfield size, orientation codes, tracker
// state encoding and the linear pixel address helper.
package lightbike_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    // Orientation word codes: +-1 steps along x, +-SCREEN_W steps along y.
    localparam logic [31:0] DIR_RIGHT = 32'h0000_0001;
    localparam logic [31:0] DIR_LEFT  = 32'hFFFF_FFFF;
    localparam logic [31:0] DIR_DOWN  = 32'd640;
    localparam logic [31:0] DIR_UP    = 32'hFFFF_FD80;
    localparam logic [31:0] DIR_STOP  = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_FETCH,
        ST_CHECK,
        ST_CRASHED
    } state_t;

    // Linear framebuffer address y*w+x, computed at full 32-bit width.
    function automatic logic [31:0] lin_addr(input logic [9:0]  x,
                                             input logic [8:0]  y,
                                             input int unsigned w);
        return ({23'd0, y} * w) + {22'd0, x};
    endfunction

endpackage

// File: rtl/bike_motion_tracker_orient_decode.sv
// Combinational direction decoder: filters the orientation word against the
// last applied direction and flags moves that would leave the playfield.
module orient_decode #(
    parameter int unsigned SCREEN_W = lightbike_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H = lightbike_pkg::SCREEN_H
) (
    input  logic [31:0] orient,
    input  logic [31:0] last_dir,
    input  logic [9:0]  pos_x,
    input  logic [8:0]  pos_y,
    output logic [1:0]  dx,
    output logic [1:0]  dy,
    output logic [31:0] applied_dir,
    output logic        edge_hit,
    output logic        stop
);
    import lightbike_pkg::*;

    logic legal;
    logic reverse;

    // Pick the applied direction (illegal codes and reversals keep last_dir),
    // then derive the 2's-complement step and the edge condition from it.
    always_comb begin
        legal       = (orient == DIR_RIGHT) || (orient == DIR_LEFT) ||
                      (orient == DIR_DOWN)  || (orient == DIR_UP);
        reverse     = (orient == (32'd0 - last_dir));
        stop        = (orient == DIR_STOP);
        applied_dir = (legal && !reverse) ? orient : last_dir;
        dx          = 2'b00;
        dy          = 2'b00;
        edge_hit    = 1'b0;
        case (applied_dir)
            DIR_RIGHT: begin
                dx       = 2'b01;
                edge_hit = (pos_x == 10'(SCREEN_W - 1));
            end
            DIR_LEFT: begin
                dx       = 2'b11;
                edge_hit = (pos_x == '0);
            end
            DIR_DOWN: begin
                dy       = 2'b01;
                edge_hit = (pos_y == 9'(SCREEN_H - 1));
            end
            DIR_UP: begin
                dy       = 2'b11;
                edge_hit = (pos_y == '0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bike_motion_tracker.sv
// Advances one lightbike across the playfield once every STEP_DIV ticks,
// checking edges and trail occupancy and marking vacated pixels in the trail.
module bike_motion_tracker #(
    parameter int unsigned SCREEN_W = lightbike_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H = lightbike_pkg::SCREEN_H,
    parameter int unsigned START_X  = 320,
    parameter int unsigned START_Y  = 240,
    parameter int unsigned STEP_DIV = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        tick,
    input  logic [31:0] orient,
    output logic [31:0] trail_rd_addr,
    input  logic        trail_rd_data,
    output logic        trail_wr_en,
    output logic [31:0] trail_wr_addr,
    output logic [31:0] location,
    output logic [9:0]  pos_x,
    output logic [8:0]  pos_y,
    output logic        crash,
    output logic        running
);
    import lightbike_pkg::*;

    localparam logic [9:0]  X0       = 10'(START_X);
    localparam logic [8:0]  Y0       = 9'(START_Y);
    localparam logic [31:0] LOC0     = 32'(START_Y * SCREEN_W + START_X);
    localparam logic [31:0] CNT_LAST = 32'(STEP_DIV - 1);

    state_t      state_q, state_d;
    logic [9:0]  pos_x_q, pos_x_d;
    logic [8:0]  pos_y_q, pos_y_d;
    logic [31:0] loc_q, loc_d;
    logic        crash_q, crash_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] last_dir_q, last_dir_d;
    logic [9:0]  cand_x_q, cand_x_d;
    logic [8:0]  cand_y_q, cand_y_d;
    logic [31:0] cand_addr_q, cand_addr_d;
    logic [31:0] cand_dir_q, cand_dir_d;
    logic        wr_en;

    logic [1:0]  dec_dx, dec_dy;
    logic [31:0] dec_dir;
    logic        dec_edge, dec_stop;
    logic [9:0]  step_x;
    logic [8:0]  step_y;

    orient_decode #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_decode (
        .orient      (orient),
        .last_dir    (last_dir_q),
        .pos_x       (pos_x_q),
        .pos_y       (pos_y_q),
        .dx          (dec_dx),
        .dy          (dec_dy),
        .applied_dir (dec_dir),
        .edge_hit    (dec_edge),
        .stop        (dec_stop)
    );

    // Candidate coordinates one pixel along the decoded direction.
    always_comb begin
        step_x = pos_x_q;
        step_y = pos_y_q;
        case (dec_dx)
            2'b01:   step_x = pos_x_q + 10'd1;
            2'b11:   step_x = pos_x_q - 10'd1;
            default: ;
        endcase
        case (dec_dy)
            2'b01:   step_y = pos_y_q + 9'd1;
            2'b11:   step_y = pos_y_q - 9'd1;
            default: ;
        endcase
    end

    // Next-state and step control; start overrides everything but reset.
    always_comb begin
        state_d     = state_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        loc_d       = loc_q;
        crash_d     = crash_q;
        cnt_d       = cnt_q;
        last_dir_d  = last_dir_q;
        cand_x_d    = cand_x_q;
        cand_y_d    = cand_y_q;
        cand_addr_d = cand_addr_q;
        cand_dir_d  = cand_dir_q;
        wr_en       = 1'b0;

        if (start) begin
            // A new round also resets the heading so the first step is not
            // judged against the previous round's direction.
            state_d    = ST_RUN;
            pos_x_d    = X0;
            pos_y_d    = Y0;
            loc_d      = LOC0;
            crash_d    = 1'b0;
            cnt_d      = '0;
            last_dir_d = DIR_RIGHT;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_RUN: begin
                    if (tick) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_d = '0;
                            if (dec_stop || dec_edge) begin
                                state_d = ST_CRASHED;
                                crash_d = 1'b1;
                            end else begin
                                state_d     = ST_FETCH;
                                cand_x_d    = step_x;
                                cand_y_d    = step_y;
                                cand_addr_d = lin_addr(step_x, step_y, SCREEN_W);
                                cand_dir_d  = dec_dir;
                            end
                        end else begin
                            cnt_d = cnt_q + 32'd1;
                        end
                    end
                end
                ST_FETCH: state_d = ST_CHECK;
                ST_CHECK: begin
                    if (trail_rd_data) begin
                        state_d = ST_CRASHED;
                        crash_d = 1'b1;
                    end else begin
                        wr_en      = !reset;
                        pos_x_d    = cand_x_q;
                        pos_y_d    = cand_y_q;
                        loc_d      = cand_addr_q;
                        last_dir_d = cand_dir_q;
                        state_d    = ST_RUN;
                    end
                end
                ST_CRASHED: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and position registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pos_x_q     <= X0;
            pos_y_q     <= Y0;
            loc_q       <= LOC0;
            crash_q     <= 1'b0;
            cnt_q       <= '0;
            last_dir_q  <= DIR_RIGHT;
            cand_x_q    <= X0;
            cand_y_q    <= Y0;
            cand_addr_q <= LOC0;
            cand_dir_q  <= DIR_RIGHT;
        end else begin
            state_q     <= state_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            loc_q       <= loc_d;
            crash_q     <= crash_d;
            cnt_q       <= cnt_d;
            last_dir_q  <= last_dir_d;
            cand_x_q    <= cand_x_d;
            cand_y_q    <= cand_y_d;
            cand_addr_q <= cand_addr_d;
            cand_dir_q  <= cand_dir_d;
        end
    end

    assign trail_rd_addr = cand_addr_q;
    assign trail_wr_en   = wr_en;
    assign trail_wr_addr = loc_q;
    assign location      = loc_q;
    assign pos_x         = pos_x_q;
    assign pos_y         = pos_y_q;
    assign crash         = crash_q;
    assign running       = (state_q == ST_RUN) || (state_q == ST_FETCH) ||
                           (state_q == ST_CHECK);

endmodule
